pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload bit width; legal range 1..256.
REQ-002 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter NOP_VALUE, default all-zero WIDTH bits: payload driven whenever the stage holds a bubble.
REQ-004 Parameter CNT_W, default 16: stall-counter width; legal range 1..32.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: upstream offers in_data this cycle.
REQ-008 Port in_ready, output, 1: stage accepts in_data this cycle.
REQ-009 Port in_data, input, WIDTH: upstream payload.
REQ-010 Port out_valid, output, 1: out_data is a live payload.
REQ-011 Port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-012 Port out_data, output, WIDTH: registered payload to the next stage.
REQ-013 Port flush, input, 1: kill all held and incoming payloads.
REQ-014 Port stall_cnt, output, CNT_W: saturating count of back-pressure cycles.

Function
REQ-015 Transfer-in SHALL occur when in_valid and in_ready are both 1; transfer-out SHALL occur when out_valid and out_ready are both 1.
REQ-016 Latency in_data to out_data SHALL be exactly one cycle when the stage is empty or out_ready=1.
REQ-017 out_data SHALL equal NOP_VALUE whenever out_valid=0.
REQ-018 The main register SHALL load when out_valid=0 or out_ready=1, from the skid entry if it is occupied, else from in_data on transfer-in, else it SHALL become a bubble.
REQ-019 SKID=1: in_ready SHALL be a register output, equal to 1 exactly when the skid entry is empty.
REQ-020 SKID=1: the skid entry SHALL capture in_data on transfer-in while out_valid=1 and out_ready=0, and SHALL drain into the main register on the next main-register load.
REQ-021 SKID=1: payload order SHALL be preserved; at most two payloads are held; no payload is dropped or duplicated.
REQ-022 SKID=0: in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-023 With out_valid=1 and out_ready=0, out_data and out_valid SHALL hold unchanged.
REQ-024 flush=1 SHALL, at the next edge, clear out_valid and the skid entry, drive out_data to NOP_VALUE, and discard any same-cycle transfer-in; flush SHALL override all other updates.
REQ-025 While flush=1, in_ready SHALL still follow REQ-019/REQ-022, so upstream handshakes complete and are discarded.
REQ-026 stall_cnt SHALL increment by 1 on every edge where out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1, and SHALL not be cleared by flush.

Reset
REQ-027 rst=1 SHALL, at the next rising edge, set out_valid=0, out_data=NOP_VALUE, skid entry empty, in_ready=1 (SKID=1), and stall_cnt=0.
REQ-028 rst SHALL take priority over flush and all handshakes; payloads in flight at reset SHALL be discarded.

Structure
REQ-029 A shared package pipe_pkg SHALL hold the default NOP payload constant and the default CNT_W.
REQ-030 The skid entry SHALL be a sub-module pipe_skid_entry (valid bit plus WIDTH payload, load/clear controls), instantiated only when SKID=1.

Verification
REQ-031 Reset, then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, out_valid=1 throughout.
REQ-032 SKID=1: out_ready=0 with 0x11 held, offer 0x22 -> accepted, in_ready=0 next cycle; out_ready=1 -> outputs 0x11 then 0x22, no loss.
REQ-033 Two payloads held, flush=1 for one cycle with in_valid=1, in_data=0x44 -> out_valid=0, out_data=NOP_VALUE next cycle; 0x44 never appears at out_data.
REQ-034 CNT_W=2: out_ready=0 for 6 cycles with out_valid=1 -> stall_cnt reads 1,2,3,3,3,3.
REQ-035 rst asserted while a payload is held and the skid entry is full -> next cycle out_valid=0, in_ready=1, stall_cnt=0.
REQ-036 SKID=0, out_valid=1, out_ready toggling each cycle -> in_ready mirrors out_ready in the same cycle and order is preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline stage register
package pipe_pkg;

  localparam int PIPE_MAX_W = 256;
  localparam int PIPE_CNT_W = 16;
  localparam logic [PIPE_MAX_W-1:0] PIPE_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one-deep overflow slot (valid bit plus payload)
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // clear wins over load so a flush can never leave a stale entry behind
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= PIPE_NOP[WIDTH-1:0];
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with optional skid slot
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = PIPE_NOP[WIDTH-1:0],
  parameter int               CNT_W     = PIPE_CNT_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             xfer_in;
  logic             main_load;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign xfer_in   = in_valid && in_ready;
  assign main_load = !out_valid || out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clear;
      logic skid_next;
      logic rdy_q;

      // only capture when the main register is blocked by the downstream
      assign skid_load  = xfer_in && out_valid && !out_ready && !flush;
      assign skid_clear = flush || (main_load && skid_valid);

      always_comb begin
        skid_next = skid_valid;
        if (skid_clear)     skid_next = 1'b0;
        else if (skid_load) skid_next = 1'b1;
      end

      pipe_skid_entry #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .data  (in_data),
        .valid (skid_valid),
        .q     (skid_data)
      );

      always_ff @(posedge clk) begin
        if (rst) rdy_q <= 1'b1;
        else     rdy_q <= !skid_next;
      end

      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = NOP_VALUE;
      assign in_ready   = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
    end else if (main_load) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
      end else if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_data  <= NOP_VALUE;
      end
    end
  end

  // back-pressure counter survives flush; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed bench for skid and no-skid stage variants
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_stall;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [7:0] b_in_data, b_out_data;
  logic [15:0] b_stall;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .NOP_VALUE(8'hEE), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .stall_cnt(b_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_flush = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_flush = 0;
    do_reset();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 8'hEE) begin errors++; $display("FAIL reset_a_data: got %h expected ee", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_stall !== 2'd0) begin errors++; $display("FAIL reset_a_stall: got %0d expected 0", a_stall); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_out_valid); end
    checks++; if (b_out_data !== 8'h00) begin errors++; $display("FAIL reset_b_data: got %h expected 00", b_out_data); end
  endtask

  task automatic test_stream();
    logic [7:0] vec [3];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    a_out_ready = 1; a_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = vec[i];
      step();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== vec[i]) begin errors++; $display("FAIL stream_%0d: got v=%b d=%h expected v=1 d=%h", i, a_out_valid, a_out_data, vec[i]); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b expected 1", i, a_in_ready); end
    end
    a_in_valid = 0;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hEE) begin errors++; $display("FAIL stream_bubble: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
  endtask

  task automatic test_skid();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h11;
    step();
    a_in_data = 8'h22;
    step();
    checks++; if (a_out_data !== 8'h11 || a_out_valid !== 1'b1) begin errors++; $display("FAIL skid_hold: got v=%b d=%h expected v=1 d=11", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready: got %b expected 0", a_in_ready); end
    a_in_valid = 0; a_out_ready = 1;
    step();
    checks++; if (a_out_data !== 8'h22 || a_out_valid !== 1'b1) begin errors++; $display("FAIL skid_drain: got v=%b d=%h expected v=1 d=22", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b expected 1", a_in_ready); end
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hEE) begin errors++; $display("FAIL skid_empty: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
  endtask

  task automatic test_flush();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h55;
    step();
    a_in_data = 8'h66;
    step();
    a_flush = 1; a_in_data = 8'h44;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hEE) begin errors++; $display("FAIL flush_full: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_stall !== 2'd2) begin errors++; $display("FAIL flush_keeps_stall: got %0d expected 2", a_stall); end
    // stage now empty and ready, so this 0x44 really handshakes and must vanish
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hEE) begin errors++; $display("FAIL flush_discard: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data === 8'h44) begin errors++; $display("FAIL flush_no_44: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
  endtask

  task automatic test_stall();
    logic [1:0] exp_cnt [6];
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3; exp_cnt[5] = 3;
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h77;
    step();
    a_in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (a_stall !== exp_cnt[i]) begin errors++; $display("FAIL stall_cnt_%0d: got %0d expected %0d", i, a_stall, exp_cnt[i]); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h77) begin errors++; $display("FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=77", i, a_out_valid, a_out_data); end
    end
    a_out_ready = 1;
    step();
  endtask

  task automatic test_reset_full();
    do_reset();
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h88;
    step();
    a_in_data = 8'h99;
    step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_pre_ready: got %b expected 0", a_in_ready); end
    rst = 1; a_flush = 1;
    step();
    rst = 0; a_flush = 0; a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hEE) begin errors++; $display("FAIL rstfull_out: got v=%b d=%h expected v=0 d=ee", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_stall !== 2'd0) begin errors++; $display("FAIL rstfull_stall: got %0d expected 0", a_stall); end
    a_out_ready = 1;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_no_ghost: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_noskid();
    b_in_valid = 1; b_in_data = 8'hA1; b_out_ready = 0;
    step();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hA1) begin errors++; $display("FAIL noskid_load: got v=%b d=%h expected v=1 d=a1", b_out_valid, b_out_data); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_rdy0_a: got %b expected 0", b_in_ready); end
    b_in_data = 8'hA2;
    step();
    checks++; if (b_out_data !== 8'hA1) begin errors++; $display("FAIL noskid_hold: got %h expected a1", b_out_data); end
    b_out_ready = 1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_rdy1_a: got %b expected 1", b_in_ready); end
    step();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hA2) begin errors++; $display("FAIL noskid_a2: got v=%b d=%h expected v=1 d=a2", b_out_valid, b_out_data); end
    b_in_data = 8'hA3; b_out_ready = 0;
    #1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_rdy0_b: got %b expected 0", b_in_ready); end
    step();
    checks++; if (b_out_data !== 8'hA2) begin errors++; $display("FAIL noskid_hold2: got %h expected a2", b_out_data); end
    b_out_ready = 1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_rdy1_b: got %b expected 1", b_in_ready); end
    step();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hA3) begin errors++; $display("FAIL noskid_a3: got v=%b d=%h expected v=1 d=a3", b_out_valid, b_out_data); end
    b_in_valid = 0;
    step();
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== 8'h00) begin errors++; $display("FAIL noskid_bubble: got v=%b d=%h expected v=0 d=00", b_out_valid, b_out_data); end
    checks++; if (b_stall !== 16'd2) begin errors++; $display("FAIL noskid_stall: got %0d expected 2", b_stall); end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall();
    test_reset_full();
    test_noskid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
